// File: rtl/logicnets_input_framer_if.sv
// Handshake bundle between the I/Q sample source, the input framer and the layer-0 LUT bank.
// The slave view belongs to the framer; the master view belongs to whatever drives and consumes it.
interface logicnets_input_framer_if #(
    parameter int unsigned SAMPLE_W    = 12,
    parameter int unsigned NUM_SAMPLES = 32
);
    localparam int unsigned FEAT_W = 2 * NUM_SAMPLES;

    logic                       s_valid;
    logic                       s_ready;
    logic signed [SAMPLE_W-1:0] s_i;
    logic signed [SAMPLE_W-1:0] s_q;
    logic                       s_last;

    logic                       m_valid;
    logic                       m_ready;
    logic [FEAT_W-1:0]          m_feat;
    logic                       m_err;

    modport slave (
        input  s_valid, s_i, s_q, s_last, m_ready,
        output s_ready, m_valid, m_feat, m_err
    );

    modport master (
        output s_valid, s_i, s_q, s_last, m_ready,
        input  s_ready, m_valid, m_feat, m_err
    );
endinterface

// File: rtl/logicnets_input_framer.sv
// Binarises a window of signed I/Q samples against per-channel thresholds and packs the
// results into one flat feature vector for the layer-0 LogicNets neurons.
module logicnets_input_framer #(
    parameter int unsigned SAMPLE_W    = 12,
    parameter int unsigned NUM_SAMPLES = 32,
    parameter int unsigned DROP_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [SAMPLE_W-1:0] thr_i,
    input  logic signed [SAMPLE_W-1:0] thr_q,
    logicnets_input_framer_if.slave    bus,
    output logic [DROP_W-1:0]          drop_cnt
);
    localparam int unsigned FEAT_W = 2 * NUM_SAMPLES;
    localparam int unsigned CNT_W  = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

    typedef enum logic [0:0] {StCollect, StDrain} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FEAT_W-1:0]   asm_q, asm_d;
    logic [FEAT_W-1:0]   feat_q, feat_d;
    logic                err_q, err_d;
    logic                valid_q, valid_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic at_last;
    logic s_ready_w;
    logic accept;
    logic i_hit;
    logic q_hit;

    assign at_last   = (cnt_q == LAST_CNT);
    // Only the window-completing beat needs the output slot, so only it can be stalled.
    assign s_ready_w = !((state_q == StCollect) && at_last && valid_q && !bus.m_ready);
    assign accept    = bus.s_valid && s_ready_w;
    assign i_hit     = (bus.s_i >= thr_i);
    assign q_hit     = (bus.s_q >= thr_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        feat_d  = feat_q;
        err_d   = err_q;
        drop_d  = drop_q;
        valid_d = valid_q && !bus.m_ready;

        if (accept) begin
            unique case (state_q)
                StCollect: begin
                    asm_d[{cnt_q, 1'b0}] = i_hit;
                    asm_d[{cnt_q, 1'b1}] = q_hit;
                    if (at_last) begin
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        feat_d  = asm_d;
                        err_d   = !bus.s_last;
                        if (!bus.s_last) begin
                            state_d = StDrain;
                        end
                    end else if (bus.s_last) begin
                        // Short window: stale assembly bits are simply overwritten by the next one.
                        cnt_d = '0;
                        if (drop_q != '1) begin
                            drop_d = drop_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (bus.s_last) begin
                        state_d = StCollect;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = StCollect;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StCollect;
            cnt_q   <= '0;
            asm_q   <= '0;
            feat_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            feat_q  <= feat_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.s_ready = s_ready_w;
    assign bus.m_valid = valid_q;
    assign bus.m_feat  = feat_q;
    assign bus.m_err   = err_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_logicnets_input_framer.sv
// Randomised bench for logicnets_input_framer: windows are scored against a per-window
// reference that applies the threshold/length rules directly.
module tb_logicnets_input_framer;
    localparam int SW = 12;
    localparam int N  = 4;
    localparam int FW = 2 * N;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic signed [SW-1:0] thr_i;
    logic signed [SW-1:0] thr_q;
    logic [DW-1:0] drop_cnt;

    always #5 clk = ~clk;

    logicnets_input_framer_if #(.SAMPLE_W(SW), .NUM_SAMPLES(N)) bus ();

    logicnets_input_framer #(.SAMPLE_W(SW), .NUM_SAMPLES(N), .DROP_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .thr_i    (thr_i),
        .thr_q    (thr_q),
        .bus      (bus),
        .drop_cnt (drop_cnt)
    );

    int tests = 0;
    int fails = 0;
    int exp_drop = 0;
    bit rand_rdy = 1'b0;
    logic [FW:0] exp_q[$];
    logic [FW:0] got_q[$];
    logic signed [SW-1:0] wi[16];
    logic signed [SW-1:0] wq[16];

    // Output monitor: a frame is delivered on every valid && ready edge.
    initial forever begin
        @(negedge clk);
        if (rst_n && bus.m_valid && bus.m_ready) got_q.push_back({bus.m_err, bus.m_feat});
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) bus.m_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [DW-1:0] drop_model();
        return (exp_drop >= 255) ? 8'hFF : DW'(exp_drop);
    endfunction

    // Reference: short windows are counted, full/long windows yield the first N beats' bits.
    task automatic model_window(input int len);
        logic [FW-1:0] f;
        f = '0;
        if (len < N) begin
            exp_drop++;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (wi[k] >= thr_i) f = f | (FW'(1) << (2 * k));
                if (wq[k] >= thr_q) f = f | (FW'(1) << (2 * k + 1));
            end
            exp_q.push_back({(len > N), f});
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 16; k++) begin
            wi[k] = SW'($urandom);
            wq[k] = SW'($urandom);
        end
    endtask

    task automatic send_beat(input logic signed [SW-1:0] i, input logic signed [SW-1:0] q,
                             input logic last, output bit ok);
        bus.s_valid = 1'b1;
        bus.s_i     = i;
        bus.s_q     = q;
        bus.s_last  = last;
        ok = 1'b0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
        end
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic send_window(input int len);
        bit ok;
        model_window(len);
        for (int k = 0; k < len; k++) begin
            send_beat(wi[k], wq[k], (k == len - 1), ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL beat_accept: beat %0d of %0d never accepted (s_ready=%b)",
                         k, len, bus.s_ready);
            end
        end
    endtask

    task automatic settle();
        for (int c = 0; c < 200 && got_q.size() < exp_q.size(); c++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_drop = 0;
        thr_i = '0;
        thr_q = '0;
        bus.s_valid = 1'b0;
        bus.s_i = '0;
        bus.s_q = '0;
        bus.s_last = 1'b0;
        bus.m_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
        tests++; if (bus.m_feat !== '0) begin fails++; $display("FAIL reset_m_feat: got %h want 0", bus.m_feat); end
        tests++; if (bus.m_err !== 1'b0) begin fails++; $display("FAIL reset_m_err: got %b want 0", bus.m_err); end
        tests++; if (drop_cnt !== '0) begin fails++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready: got %b want 1", bus.s_ready); end
    endtask

    task automatic test_nominal();
        exp_q.delete(); got_q.delete();
        bus.m_ready = 1'b1;
        wi[0] = 12'sd5;  wi[1] = -12'sd3; wi[2] = 12'sd0;  wi[3] = -12'sd1;
        wq[0] = -12'sd2; wq[1] = 12'sd7;  wq[2] = -12'sd8; wq[3] = 12'sd100;
        send_window(N);
        tests++; if (bus.m_valid !== 1'b1) begin fails++; $display("FAIL nominal_latency: m_valid got %b want 1", bus.m_valid); end
        tests++; if ({bus.m_err, bus.m_feat} !== exp_q[0]) begin fails++; $display("FAIL nominal_feat: got %h want %h", {bus.m_err, bus.m_feat}, exp_q[0]); end
        settle();
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL nominal_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[j]) begin tests++; if (got_q[j] !== exp_q[j]) begin fails++; $display("FAIL nominal_frame %0d: got %h want %h", j, got_q[j], exp_q[j]); end end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [FW:0] first;
        exp_q.delete(); got_q.delete();
        bus.m_ready = 1'b0;
        fill_rand();
        send_window(N);
        first = exp_q[0];
        fill_rand();
        model_window(N);
        for (int k = 0; k < N - 1; k++) begin
            send_beat(wi[k], wq[k], 1'b0, ok);
            tests++; if (!ok) begin fails++; $display("FAIL bp_beat %0d: not accepted", k); end
        end
        bus.s_valid = 1'b1; bus.s_i = wi[N-1]; bus.s_q = wq[N-1]; bus.s_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tests++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL bp_s_ready_stall: got %b want 0", bus.s_ready); end
            tests++; if ({bus.m_valid, bus.m_err, bus.m_feat} !== {1'b1, first}) begin fails++; $display("FAIL bp_hold: got %b/%h want 1/%h", bus.m_valid, {bus.m_err, bus.m_feat}, first); end
        end
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        tests++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL bp_s_ready_release: got %b want 1", bus.s_ready); end
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        tests++; if ({bus.m_valid, bus.m_err, bus.m_feat} !== {1'b1, exp_q[1]}) begin fails++; $display("FAIL bp_back_to_back: got %b/%h want 1/%h", bus.m_valid, {bus.m_err, bus.m_feat}, exp_q[1]); end
        settle();
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[j]) begin tests++; if (got_q[j] !== exp_q[j]) begin fails++; $display("FAIL bp_frame %0d: got %h want %h", j, got_q[j], exp_q[j]); end end
    endtask

    task automatic test_short();
        exp_q.delete(); got_q.delete();
        bus.m_ready = 1'b1;
        fill_rand();
        send_window(2);
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL short_no_output: m_valid got %b want 0", bus.m_valid); end
        tests++; if (drop_cnt !== drop_model()) begin fails++; $display("FAIL short_drop_cnt: got %0d want %0d", drop_cnt, drop_model()); end
        fill_rand();
        send_window(N);
        settle();
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL short_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[j]) begin tests++; if (got_q[j] !== exp_q[j]) begin fails++; $display("FAIL short_frame %0d: got %h want %h", j, got_q[j], exp_q[j]); end end
    endtask

    task automatic test_long();
        exp_q.delete(); got_q.delete();
        bus.m_ready = 1'b1;
        fill_rand();
        send_window(N + 2);
        fill_rand();
        send_window(N);
        settle();
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL long_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[j]) begin tests++; if (got_q[j] !== exp_q[j]) begin fails++; $display("FAIL long_frame %0d: got %h want %h", j, got_q[j], exp_q[j]); end end
        tests++; if (drop_cnt !== drop_model()) begin fails++; $display("FAIL long_drop_cnt: got %0d want %0d", drop_cnt, drop_model()); end
    endtask

    task automatic test_thresholds();
        exp_q.delete(); got_q.delete();
        bus.m_ready = 1'b1;
        thr_i = -12'sd2048;
        thr_q = 12'sd2047;
        fill_rand();
        for (int k = 0; k < N; k++) wq[k] = 12'sd2047;
        send_window(N);
        settle();
        tests++;
        if (got_q.size() != 1) begin fails++; $display("FAIL thr_count: got %0d want 1", got_q.size()); end
        else begin
            tests++; if (got_q[0] !== exp_q[0]) begin fails++; $display("FAIL thr_frame: got %h want %h", got_q[0], exp_q[0]); end
            tests++; if (got_q[0][FW-1:0] !== {FW{1'b1}}) begin fails++; $display("FAIL thr_all_ones: got %h want ff", got_q[0][FW-1:0]); end
        end
        thr_i = '0;
        thr_q = '0;
        for (int w = 0; w < 300; w++) begin
            wi[0] = SW'($urandom);
            wq[0] = SW'($urandom);
            send_window(1);
        end
        @(posedge clk); #1;
        tests++; if (drop_cnt !== 8'hFF) begin fails++; $display("FAIL drop_saturate: got %0d want 255 (model %0d)", drop_cnt, drop_model()); end
    endtask

    task automatic test_random();
        int len;
        exp_q.delete(); got_q.delete();
        rand_rdy = 1'b1;
        for (int w = 0; w < 40; w++) begin
            thr_i = SW'($urandom_range(0, 600)) - 12'sd300;
            thr_q = SW'($urandom_range(0, 600)) - 12'sd300;
            fill_rand();
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(1, N - 1);
                1:       len = $urandom_range(N + 1, 2 * N);
                default: len = N;
            endcase
            send_window(len);
        end
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        settle();
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[j]) begin tests++; if (got_q[j] !== exp_q[j]) begin fails++; $display("FAIL rand_frame %0d: got %h want %h", j, got_q[j], exp_q[j]); end end
        tests++; if (drop_cnt !== drop_model()) begin fails++; $display("FAIL rand_drop_cnt: got %0d want %0d", drop_cnt, drop_model()); end
        thr_i = '0;
        thr_q = '0;
    endtask

    task automatic test_async_reset();
        bit ok;
        exp_q.delete(); got_q.delete();
        bus.m_ready = 1'b0;
        fill_rand();
        send_window(N);
        for (int k = 0; k < 3; k++) send_beat(wi[k], wq[k], 1'b0, ok);
        tests++; if (bus.m_valid !== 1'b1) begin fails++; $display("FAIL arst_pre_valid: got %b want 1", bus.m_valid); end
        #3;
        rst_n = 1'b0;
        #1;
        tests++; if ({bus.m_valid, bus.m_err, bus.m_feat} !== '0) begin fails++; $display("FAIL arst_outputs: got %b/%b/%h want 0", bus.m_valid, bus.m_err, bus.m_feat); end
        tests++; if (drop_cnt !== '0) begin fails++; $display("FAIL arst_drop_cnt: got %0d want 0", drop_cnt); end
        exp_q.delete(); got_q.delete();
        exp_drop = 0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        fill_rand();
        send_window(N);
        settle();
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL arst_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[j]) begin tests++; if (got_q[j] !== exp_q[j]) begin fails++; $display("FAIL arst_frame %0d: got %h want %h", j, got_q[j], exp_q[j]); end end
        tests++; if (drop_cnt !== '0) begin fails++; $display("FAIL arst_drop_after: got %0d want 0", drop_cnt); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_short();
        test_long();
        test_random();
        test_thresholds();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
